// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetcher with one outstanding memory request,
// a one-entry decoder buffer, redirect flush and a drain state for stale responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    FULL,
    DRAIN
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] target;
  logic        in_flight;

  assign target    = redirect_pc & 32'hFFFF_FFFC;
  assign in_flight = (state == WAIT) || (state == DRAIN);

  assign imem_addr   = pc;
  assign imem_req    = !rst && (state == FETCH) && !redirect;
  assign instr_valid = (state == FULL) && !redirect;

  // A redirect wins over everything; an unanswered request must still drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC & 32'hFFFF_FFFC;
      instr    <= 32'h0;
      instr_pc <= 32'h0;
    end else if (redirect) begin
      pc    <= target;
      state <= (in_flight && !imem_valid) ? DRAIN : FETCH;
    end else begin
      unique case (state)
        FETCH: state <= WAIT;
        WAIT: begin
          if (imem_valid) begin
            instr    <= imem_rdata;
            instr_pc <= pc;
            pc       <= pc + 32'd4;
            state    <= FULL;
          end
        end
        FULL: begin
          if (instr_ready) state <= FETCH;
        end
        DRAIN: begin
          if (imem_valid) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch traffic against a transaction-level model
// of the fetcher, plus directed scenarios with literal expectations.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  // Second instance exercising the top-of-address-space reset vector.
  logic        r1_req;
  logic [31:0] r1_addr;
  logic        r1_valid;
  logic        r1_ivalid;
  logic [31:0] r1_instr;
  logic [31:0] r1_ipc;

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u1 (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (r1_req),
    .imem_addr   (r1_addr),
    .imem_valid  (r1_valid),
    .imem_rdata  (r1_addr ^ 32'h5A5A_5A5A),
    .instr_valid (r1_ivalid),
    .instr_ready (1'b1),
    .instr       (r1_instr),
    .instr_pc    (r1_ipc),
    .redirect    (1'b0),
    .redirect_pc (32'h0)
  );

  always @(posedge clk or posedge rst)
    if (rst) r1_valid <= 1'b0;
    else     r1_valid <= r1_req;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: outstanding request (possibly stale) and buffered word.
  logic [31:0] m_pc, m_instr, m_ipc;
  logic        m_busy, m_stale, m_buf;
  logic        e_req, e_iv;

  int          q_due[$];
  logic [31:0] q_dat[$];
  int          lat = 1;
  bit          lat_rand = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
    m_busy = 0; m_stale = 0; m_buf = 0;
    q_due.delete(); q_dat.delete();
  endtask

  // Called just after a rising edge: present memory response, then compare.
  task automatic pre();
    if (rst) model_reset();
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    if (!rst && q_due.size() > 0 && q_due[0] == cyc) begin
      imem_valid = 1'b1;
      imem_rdata = q_dat[0];
      void'(q_due.pop_front());
      void'(q_dat.pop_front());
    end
    e_req = !rst && !m_busy && !m_buf && !redirect;
    e_iv  = !rst && m_buf && !redirect;
    #3;
    chk("imem_req", {31'h0, imem_req}, {31'h0, e_req});
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", {31'h0, instr_valid}, {31'h0, e_iv});
    if (rst) begin
      chk("rst_instr", instr, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
    end else if (e_iv) begin
      chk("instr", instr, m_instr);
      chk("instr_pc", instr_pc, m_ipc);
    end
  endtask

  task automatic post();
    logic        req_s;
    logic [31:0] a_s;
    req_s = imem_req;
    a_s   = imem_addr;
    if (req_s) begin
      q_due.push_back(cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat));
      q_dat.push_back(word(a_s));
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset();
    end else if (redirect) begin
      m_pc  = redirect_pc & 32'hFFFF_FFFC;
      m_buf = 0;
      if (m_busy) begin
        if (imem_valid) begin m_busy = 0; m_stale = 0; end
        else m_stale = 1;
      end
    end else if (m_busy) begin
      if (imem_valid) begin
        if (!m_stale) begin
          m_buf = 1; m_instr = imem_rdata; m_ipc = m_pc; m_pc = m_pc + 32'd4;
        end
        m_busy = 0; m_stale = 0;
      end
    end else if (m_buf) begin
      if (instr_ready) m_buf = 0;
    end else begin
      m_busy = 1; m_stale = 0;
    end
    #1;
  endtask

  logic [31:0] s_i, s_pc;
  bit          found;

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;
    imem_valid = 1'b0; imem_rdata = 32'h0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      pre();
      chk("rst_u1_addr", r1_addr, 32'hFFFF_FFFC);
      chk("rst_u1_req", {31'h0, r1_req}, 32'h0);
      post();
    end
    rst = 1'b0;

    // Latency 1, always ready: one instruction every three cycles.
    for (int k = 0; k < 9; k++) begin
      pre();
      case (k)
        0: begin
          chk("lit_req0", {31'h0, imem_req}, 32'h1);
          chk("lit_addr0", imem_addr, 32'h0);
          chk("u1_addr0", r1_addr, 32'hFFFF_FFFC);
        end
        2: begin
          chk("lit_iv2", {31'h0, instr_valid}, 32'h1);
          chk("lit_ipc2", instr_pc, 32'h0);
          chk("lit_instr2", instr, word(32'h0));
          chk("u1_ipc", r1_ipc, 32'hFFFF_FFFC);
          chk("u1_iv", {31'h0, r1_ivalid}, 32'h1);
        end
        3: begin
          chk("lit_addr3", imem_addr, 32'h4);
          chk("u1_wrap", r1_addr, 32'h0);
          chk("u1_req3", {31'h0, r1_req}, 32'h1);
        end
        5: chk("lit_ipc5", instr_pc, 32'h4);
        6: chk("lit_addr6", imem_addr, 32'h8);
        8: chk("lit_ipc8", instr_pc, 32'h8);
        default: ;
      endcase
      post();
    end

    // Back-pressure for five cycles in the buffered state.
    lat = 2;
    instr_ready = 1'b0;
    for (int i = 0; i < 20 && !m_buf; i++) begin pre(); post(); end
    s_i = m_instr; s_pc = m_ipc;
    for (int i = 0; i < 5; i++) begin
      pre();
      chk("bp_instr", instr, s_i);
      chk("bp_ipc", instr_pc, s_pc);
      chk("bp_req", {31'h0, imem_req}, 32'h0);
      post();
    end
    instr_ready = 1'b1;
    pre(); chk("bp_hs", {31'h0, instr_valid}, 32'h1); post();
    pre(); chk("bp_next", imem_addr, s_pc + 32'd4); post();

    // Redirect in WAIT with a slow memory: stale response must be dropped.
    lat = 3;
    for (int i = 0; i < 20 && (m_busy || m_buf); i++) begin pre(); post(); end
    pre(); post();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    pre(); post();
    redirect = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      pre();
      if (imem_req) begin
        chk("rd_wait_addr", imem_addr, 32'h0000_0100);
        found = 1;
      end else begin
        chk("rd_wait_iv", {31'h0, instr_valid}, 32'h0);
      end
      post();
    end
    if (!found) begin
      errs++;
      $display("FAIL rd_wait_timeout: got no request expected one");
    end

    // Redirect together with the response, then redirect in FULL.
    lat = 1;
    for (int i = 0; i < 20 && (m_busy || m_buf); i++) begin pre(); post(); end
    pre(); post();
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    pre(); post();
    redirect = 1'b0;
    pre();
    chk("rd_coinc_addr", imem_addr, 32'h0000_0200);
    chk("rd_coinc_req", {31'h0, imem_req}, 32'h1);
    post();
    pre(); post();
    redirect = 1'b1; redirect_pc = 32'h0000_0300; instr_ready = 1'b1;
    pre(); chk("rd_full_iv", {31'h0, instr_valid}, 32'h0); post();
    redirect = 1'b0;
    pre();
    chk("rd_full_addr", imem_addr, 32'h0000_0300);
    chk("rd_full_req", {31'h0, imem_req}, 32'h1);
    post();

    // Asynchronous reset in the middle of WAIT.
    pre();
    rst = 1'b1;
    #1;
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_req", {31'h0, imem_req}, 32'h0);
    chk("arst_iv", {31'h0, instr_valid}, 32'h0);
    chk("arst_instr", instr, 32'h0);
    chk("arst_ipc", instr_pc, 32'h0);
    post();
    pre(); post();
    rst = 1'b0;
    pre();
    chk("arst_restart_req", {31'h0, imem_req}, 32'h1);
    chk("arst_restart_addr", imem_addr, 32'h0);
    post();

    // Randomized traffic.
    lat_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 999) < 3);
      redirect    = ($urandom_range(0, 99) < 8);
      redirect_pc = $urandom;
      instr_ready = ($urandom_range(0, 99) < 70);
      pre();
      post();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
